// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run sequencer.
package run_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN
    } run_state_t;

    localparam int DEF_HALT_PC = 128;
    localparam int DEF_RST_CYC = 2;
    localparam int DEF_TIMEOUT = 4096;

endpackage

// File: rtl/run_watchdog.sv
// Saturating RUN-cycle counter with a limit-hit compare.
module run_watchdog #(
    parameter int CW    = 16,
    parameter int LIMIT = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          hit
);

    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] MAX  = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != MAX) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == LAST);

endmodule

// File: rtl/run_sequencer.sv
// Run controller: req/done handshake, core reset/enable sequencing,
// watchdog stop and data-memory write-port arbitration.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int D       = 12,
    parameter int HALT_PC = DEF_HALT_PC,
    parameter int RST_CYC = DEF_RST_CYC,
    parameter int CW      = 16,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [D-1:0]  prog_ctr,
    input  logic          halt,
    input  logic          host_mem_wr_en,
    input  logic [7:0]    host_mem_addr,
    input  logic [7:0]    host_mem_dat,
    input  logic          core_mem_wr_en,
    input  logic [7:0]    core_mem_addr,
    input  logic [7:0]    core_mem_dat,
    output logic          mem_wr_en,
    output logic [7:0]    mem_addr,
    output logic [7:0]    mem_dat,
    output logic          host_grant,
    output logic          core_reset,
    output logic          core_en,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_count
);

    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYC - 1);
    localparam logic [D-1:0]  HALT_V   = D'(HALT_PC);

    run_state_t    state;
    run_state_t    next;
    logic          req_q;
    logic          start;
    logic [RW-1:0] rst_cnt;
    logic          start_run;
    logic          set_done;
    logic          set_to;
    logic          stop_hit;
    logic          end_prog;

    assign start    = req & ~req_q;
    assign end_prog = halt | (prog_ctr == HALT_V);

    run_watchdog #(
        .CW    (CW),
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_run),
        .enable (state == RUN),
        .count  (cycle_count),
        .hit    (stop_hit)
    );

    always_comb begin
        next       = state;
        start_run  = 1'b0;
        set_done   = 1'b0;
        set_to     = 1'b0;
        host_grant = 1'b1;
        core_reset = 1'b1;
        core_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next      = CLEAR;
                    start_run = 1'b1;
                end
            end
            CLEAR: begin
                host_grant = 1'b0;
                if (!req) begin
                    next = IDLE;
                end else if (rst_cnt == '0) begin
                    next = RUN;
                end
            end
            RUN: begin
                host_grant = 1'b0;
                core_reset = 1'b0;
                core_en    = 1'b1;
                // Abort beats halt, and halt beats the watchdog.
                if (!req) begin
                    next = IDLE;
                end else if (end_prog) begin
                    next     = IDLE;
                    set_done = 1'b1;
                end else if (stop_hit) begin
                    next     = IDLE;
                    set_done = 1'b1;
                    set_to   = 1'b1;
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            rst_cnt <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state <= next;
            req_q <= req;
            if (start_run) begin
                rst_cnt <= RST_LOAD;
            end else if (state == CLEAR && rst_cnt != '0) begin
                rst_cnt <= rst_cnt - 1'b1;
            end
            if (start_run) begin
                done    <= 1'b0;
                timeout <= 1'b0;
            end else if (set_done) begin
                done    <= 1'b1;
                timeout <= set_to;
            end
        end
    end

    always_comb begin
        if (host_grant) begin
            mem_wr_en = host_mem_wr_en;
            mem_addr  = host_mem_addr;
            mem_dat   = host_mem_dat;
        end else begin
            mem_wr_en = core_mem_wr_en & core_en;
            mem_addr  = core_mem_addr;
            mem_dat   = core_mem_dat;
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed self-checking bench for run_sequencer.
module tb_run_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [11:0] prog_ctr;
    logic        halt;
    logic        host_mem_wr_en;
    logic [7:0]  host_mem_addr;
    logic [7:0]  host_mem_dat;
    logic        core_mem_wr_en;
    logic [7:0]  core_mem_addr;
    logic [7:0]  core_mem_dat;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_dat;
    logic        host_grant;
    logic        core_reset;
    logic        core_en;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    run_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .prog_ctr       (prog_ctr),
        .halt           (halt),
        .host_mem_wr_en (host_mem_wr_en),
        .host_mem_addr  (host_mem_addr),
        .host_mem_dat   (host_mem_dat),
        .core_mem_wr_en (core_mem_wr_en),
        .core_mem_addr  (core_mem_addr),
        .core_mem_dat   (core_mem_dat),
        .mem_wr_en      (mem_wr_en),
        .mem_addr       (mem_addr),
        .mem_dat        (mem_dat),
        .host_grant     (host_grant),
        .core_reset     (core_reset),
        .core_en        (core_en),
        .done           (done),
        .timeout        (timeout),
        .cycle_count    (cycle_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From IDLE with req low: raise req and step to the first RUN cycle.
    task automatic launch();
        req = 1'b1;
        tick();
        tick();
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        req            = 1'b0;
        prog_ctr       = '0;
        halt           = 1'b0;
        host_mem_wr_en = 1'b0;
        host_mem_addr  = '0;
        host_mem_dat   = '0;
        core_mem_wr_en = 1'b0;
        core_mem_addr  = '0;
        core_mem_dat   = '0;
        tick();
        check("rst_core_reset", core_reset, 1);
        check("rst_core_en", core_en, 0);
        check("rst_host_grant", host_grant, 1);
        check("rst_done", done, 0);
        check("rst_count", cycle_count, 0);
        reset = 1'b0;
        tick();

        host_mem_wr_en = 1'b1;
        host_mem_addr  = 8'h10;
        host_mem_dat   = 8'hA5;
        core_mem_addr  = 8'h33;
        core_mem_dat   = 8'h5C;
        #1;
        check("idle_wr_en", mem_wr_en, 1);
        check("idle_addr", mem_addr, 8'h10);
        check("idle_dat", mem_dat, 8'hA5);
        check("idle_grant", host_grant, 1);
        check("idle_done", done, 0);

        // Normal run ending at prog_ctr == 128.
        core_mem_wr_en = 1'b1;
        req = 1'b1;
        tick();
        check("clr1_core_reset", core_reset, 1);
        check("clr1_grant", host_grant, 0);
        check("clr1_wr_masked", mem_wr_en, 0);
        check("clr1_addr", mem_addr, 8'h33);
        tick();
        check("clr2_core_reset", core_reset, 1);
        check("clr2_wr_masked", mem_wr_en, 0);
        tick();
        check("run_core_reset", core_reset, 0);
        check("run_core_en", core_en, 1);
        check("run_wr_core", mem_wr_en, 1);
        check("run_dat", mem_dat, 8'h5C);
        check("run_count0", cycle_count, 0);
        host_mem_wr_en = 1'b0;
        core_mem_wr_en = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            prog_ctr = (k == 40) ? 12'd128 : 12'(k);
            if (k == 40) check("pc_done_before", done, 0);
            tick();
        end
        check("pc_done", done, 1);
        check("pc_count", cycle_count, 40);
        check("pc_timeout", timeout, 0);
        check("pc_grant", host_grant, 1);
        tick();
        check("pc_done_sticky", done, 1);

        // Runaway program: watchdog stop after 4096 RUN cycles.
        req = 1'b0;
        prog_ctr = '0;
        tick();
        req = 1'b1;
        tick();
        check("to_done_cleared", done, 0);
        tick();
        tick();
        for (int k = 0; k < 4096; k++) begin
            prog_ctr = 12'(k % 6);
            if (k == 4095) check("to_done_before", done, 0);
            tick();
        end
        check("to_done", done, 1);
        check("to_timeout", timeout, 1);
        check("to_count", cycle_count, 4096);

        // Halt on the same cycle as the watchdog limit: halt wins.
        req = 1'b0;
        tick();
        launch();
        check("hw_timeout_cleared", timeout, 0);
        for (int k = 0; k < 4095; k++) begin
            prog_ctr = 12'(k % 6);
            tick();
        end
        check("hw_count_limit", cycle_count, 4095);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("hw_done", done, 1);
        check("hw_timeout", timeout, 0);
        check("hw_count", cycle_count, 4096);

        // Abort by dropping req in RUN cycle 10, then re-run.
        req = 1'b0;
        prog_ctr = '0;
        tick();
        launch();
        for (int k = 1; k < 10; k++) tick();
        req = 1'b0;
        tick();
        check("ab_done", done, 0);
        check("ab_core_reset", core_reset, 1);
        check("ab_grant", host_grant, 1);
        check("ab_count", cycle_count, 10);
        req = 1'b1;
        tick();
        check("re_count", cycle_count, 0);
        check("re_grant", host_grant, 0);
        tick();
        tick();
        for (int k = 0; k < 5; k++) tick();
        check("re_count5", cycle_count, 5);
        check("re_core_en", core_en, 1);

        // Asynchronous reset in the middle of a clock phase.
        #2;
        reset = 1'b1;
        #1;
        check("ar_core_reset", core_reset, 1);
        check("ar_core_en", core_en, 0);
        check("ar_done", done, 0);
        check("ar_count", cycle_count, 0);
        check("ar_grant", host_grant, 1);
        req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("post_idle_reset", core_reset, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
